// File: rtl/sys_bridge_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bridge_n_if
//  Brief    : CPU-side and device-side signal bundle of the system-bus bridge.
//  Revision : 1.0 - initial release
// ============================================================================
interface sys_bridge_n_if #(
  parameter int N_DEV = 2
);
  logic                  PrReq;
  logic                  PrWE;
  logic [31:0]           PrAddr;
  logic [31:0]           PrWD;
  logic [31:0]           PrRD;
  logic                  PrReady;
  logic                  PrErr;
  logic [31:0]           DEV_Addr;
  logic [31:0]           DEV_WD;
  logic [N_DEV-1:0]      DEV_Sel;
  logic [N_DEV-1:0]      DEV_We;
  logic [32*N_DEV-1:0]   DEV_RD;
  logic [N_DEV-1:0]      DEV_Ack;
  logic [N_DEV-1:0]      DEV_Irq;
  logic [5:0]            HWInt;

  // Bridge view: receives CPU requests and device responses.
  modport slave (
    input  PrReq, PrWE, PrAddr, PrWD, DEV_RD, DEV_Ack, DEV_Irq,
    output PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_Sel, DEV_We, HWInt
  );

  // Environment view: CPU plus the attached peripherals.
  modport master (
    output PrReq, PrWE, PrAddr, PrWD, DEV_RD, DEV_Ack, DEV_Irq,
    input  PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_Sel, DEV_We, HWInt
  );
endinterface
`default_nettype wire

// File: rtl/sys_bridge_n.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bridge_n
//  Brief    : CPU-to-peripheral bridge: window decode, ack/timeout handshake,
//             registered read data and 2-flop interrupt synchronisers.
//  Revision : 1.0 - initial release
// ============================================================================
module sys_bridge_n #(
  parameter int          N_DEV      = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
  parameter logic [31:0] STRIDE     = 32'h10,
  parameter int          WIN_BITS   = 4,
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] DEFAULT_RD = 32'h0
) (
  input  logic           clk,
  input  logic           reset,
  sys_bridge_n_if.slave  bus
);

  localparam int         c_IDX_W   = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [N_DEV-1:0]    r_irqMeta;
  logic [N_DEV-1:0]    r_irqSync;

  logic                w_hit;
  logic [c_IDX_W-1:0]  w_hitIdx;
  logic [N_DEV-1:0]    w_hitOneHot;
  logic                w_ack;
  logic [31:0]         w_devRd;

  function automatic logic [31:0] winBase(input int idx);
    return BASE_ADDR + STRIDE * 32'(idx);
  endfunction

  // Scan from the top index down so the lowest matching window wins.
  always_comb begin
    logic [31:0] base;
    w_hit    = 1'b0;
    w_hitIdx = '0;
    base     = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      base = winBase(i);
      if (bus.PrAddr[31:WIN_BITS] == base[31:WIN_BITS]) begin
        w_hit    = 1'b1;
        w_hitIdx = c_IDX_W'(i);
      end
    end
  end

  assign w_hitOneHot = N_DEV'(1) << w_hitIdx;
  assign w_ack       = bus.DEV_Ack[r_idx];
  assign w_devRd     = bus.DEV_RD[r_idx*32 +: 32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      bus.PrRD     <= '0;
      bus.PrReady  <= 1'b0;
      bus.PrErr    <= 1'b0;
      bus.DEV_Addr <= '0;
      bus.DEV_WD   <= '0;
      bus.DEV_Sel  <= '0;
      bus.DEV_We   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.PrReq) begin
            bus.DEV_Addr <= bus.PrAddr;
            bus.DEV_WD   <= bus.PrWD;
            r_idx        <= w_hitIdx;
            r_cnt        <= '0;
            if (w_hit) begin
              r_state     <= ACCESS;
              bus.DEV_Sel <= w_hitOneHot;
              bus.DEV_We  <= bus.PrWE ? w_hitOneHot : '0;
            end else begin
              r_state     <= DONE;
              bus.PrRD    <= DEFAULT_RD;
              bus.PrErr   <= 1'b1;
              bus.PrReady <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // An ack on the final timeout cycle still completes normally.
          if (w_ack) begin
            r_state     <= DONE;
            bus.PrRD    <= w_devRd;
            bus.PrErr   <= 1'b0;
            bus.PrReady <= 1'b1;
            bus.DEV_Sel <= '0;
            bus.DEV_We  <= '0;
          end else if (r_cnt == c_TO_LAST) begin
            r_state     <= DONE;
            bus.PrRD    <= DEFAULT_RD;
            bus.PrErr   <= 1'b1;
            bus.PrReady <= 1'b1;
            bus.DEV_Sel <= '0;
            bus.DEV_We  <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          bus.PrReady <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          bus.PrReady <= 1'b0;
          bus.DEV_Sel <= '0;
          bus.DEV_We  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqMeta <= '0;
      r_irqSync <= '0;
    end else begin
      r_irqMeta <= bus.DEV_Irq;
      r_irqSync <= r_irqMeta;
    end
  end

  generate
    if (N_DEV < 6) begin : g_hwIntPad
      assign bus.HWInt = {{(6 - N_DEV){1'b0}}, r_irqSync};
    end else begin : g_hwIntFull
      assign bus.HWInt = r_irqSync;
    end
  endgenerate

endmodule
`default_nettype wire
